// File: rtl/alu_src_b_pkg.sv
// Shared definitions for the ALU source-B operand stage: select encodings and
// the state encoding of the two-entry operand skid buffer.
package alu_src_b_pkg;

    localparam logic [2:0] SRC_B_REG     = 3'd0;
    localparam logic [2:0] SRC_B_INC     = 3'd1;
    localparam logic [2:0] SRC_B_SEXT    = 3'd2;
    localparam logic [2:0] SRC_B_MDR     = 3'd3;
    localparam logic [2:0] SRC_B_SEXT_SL = 3'd4;
    localparam logic [2:0] SRC_B_ZEXT    = 3'd5;
    localparam logic [2:0] SRC_B_LUI     = 3'd6;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } buf_state_e;

endpackage

// File: rtl/operand_skid_buffer.sv
// Two-entry valid/ready skid buffer: main drives the output, skid absorbs one
// extra accept while main is stalled. in_ready is registered.
module operand_skid_buffer
    import alu_src_b_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    buf_state_e       state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_ready_q, in_ready_d;
    logic             accept;
    logic             drain;

    assign accept = in_valid && in_ready_q;
    assign drain  = (state_q != StEmpty) && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            StEmpty: begin
                if (accept) begin
                    main_d  = in_data;
                    state_d = StOne;
                end
            end
            StOne: begin
                if (accept && drain) begin
                    main_d = in_data;
                end else if (accept) begin
                    skid_d  = in_data;
                    state_d = StFull;
                end else if (drain) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                if (drain) begin
                    main_d  = skid_q;
                    state_d = StOne;
                end
            end
            default: state_d = StEmpty;
        endcase
        in_ready_d = (state_d != StFull);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StEmpty;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != StEmpty);
    assign out_data  = main_q;

endmodule

// File: rtl/alu_operand_b_stage.sv
// Registered ALU source-B operand select/extend stage with skid-buffered output.
// Define ALU_SRC_B_LUI_EN to make select 6 a load-upper-immediate operand.
module alu_operand_b_stage
    import alu_src_b_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned IMM_W     = 16,
    parameter int unsigned CONST_INC = 4,
    parameter int unsigned SHIFT     = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       sel,
    input  logic [WIDTH-1:0] reg_b,
    input  logic [WIDTH-1:0] mdr,
    input  logic [IMM_W-1:0] imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] operand,
    output logic             sel_err,
    input  logic             err_clr
);

    logic [WIDTH-1:0] imm_sext;
    logic [WIDTH-1:0] imm_zext;
    logic [WIDTH-1:0] selected;
    logic             legal;
    logic             accept;
    logic             sel_err_q, sel_err_d;

    assign imm_sext = {{(WIDTH-IMM_W){imm[IMM_W-1]}}, imm};
    assign imm_zext = {{(WIDTH-IMM_W){1'b0}}, imm};
    assign accept   = in_valid && in_ready;

    always_comb begin
        selected = '0;
        legal    = 1'b1;
        case (sel)
            SRC_B_REG:     selected = reg_b;
            SRC_B_INC:     selected = WIDTH'(CONST_INC);
            SRC_B_SEXT:    selected = imm_sext;
            SRC_B_MDR:     selected = mdr;
            SRC_B_SEXT_SL: selected = imm_sext << SHIFT;
            SRC_B_ZEXT:    selected = imm_zext;
`ifdef ALU_SRC_B_LUI_EN
            SRC_B_LUI:     selected = imm_zext << 16;
`endif
            default:       legal    = 1'b0;
        endcase
    end

    // An illegal accept sets the flag and wins over a same-cycle clear.
    always_comb begin
        sel_err_d = sel_err_q;
        if (accept && !legal) begin
            sel_err_d = 1'b1;
        end else if (err_clr) begin
            sel_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= sel_err_d;
        end
    end

    assign sel_err = sel_err_q;

    // Illegal requests are consumed here and never reach the buffer.
    operand_skid_buffer #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid && legal),
        .in_ready  (in_ready),
        .in_data   (selected),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (operand)
    );

endmodule

// File: doc/alu_operand_b_stage.md
# alu_operand_b_stage

Parametrised, registered successor to the ALU source-B multiplexer of the multicycle datapath. Selects the ALU B operand from register B, a constant increment, MDR or one of several immediate forms (sign/zero-extended, shifted), and does the extension and shifting internally. The result is delivered through a two-entry skid buffer with valid/ready handshakes on both sides. Illegal selects raise a sticky error instead of holding a stale value. Sits between the register file/MDR outputs and the ALU B input.

## Interface
Parameters:
- WIDTH, 32, datapath/operand width in bits (≥ IMM_W + SHIFT)
- IMM_W, 16, raw immediate width
- CONST_INC, 4, constant driven for select 1 (PC increment)
- SHIFT, 2, left shift applied to select 4 (branch offset word alignment)

Ports:
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  request carries a valid select/operand set
- in_ready  out  1  stage can accept a request this cycle
- sel  in  3  operand select
- reg_b  in  WIDTH  register B contents
- mdr  in  WIDTH  memory data register contents
- imm  in  IMM_W  raw instruction immediate
- out_valid  out  1  operand output valid
- out_ready  in  1  ALU consumes operand this cycle
- operand  out  WIDTH  selected operand
- sel_err  out  1  sticky: an illegal select was accepted
- err_clr  in  1  synchronous clear of sel_err

## Operation
- Select map:
  - 0: reg_b
  - 1: CONST_INC, zero-extended to WIDTH
  - 2: imm sign-extended to WIDTH
  - 3: mdr
  - 4: (imm sign-extended) << SHIFT, truncated to WIDTH
  - 5: imm zero-extended to WIDTH
  - 6: see Configuration
  - 7: illegal
- Transfer: a request is accepted when in_valid && in_ready; sel, reg_b, mdr and imm are sampled only on that edge.
- Illegal select:
  - The request is accepted and consumed, and it is not forwarded.
  - sel_err sets on the accepting edge; operand and out_valid are unaffected.
- Error flag: err_clr clears sel_err. If err_clr and a new illegal accept fall in the same cycle, set wins.
- Skid buffer has two entries, main (drives operand) and skid:
  - Accept while main is empty, or while main is being drained (out_ready): the request loads main.
  - Accept while main is full and not draining: the request loads skid, and in_ready is 0 from the next cycle.
  - Drain while skid is full: main loads from skid, skid empties, and in_ready is 1 from the next cycle.
- States: EMPTY (out_valid=0), ONE (main only), FULL (main and skid, in_ready=0). Transitions:
  - EMPTY→ONE on accept.
  - ONE→EMPTY on drain without accept.
  - ONE→FULL on accept without drain.
  - FULL→ONE on drain; no accept is possible in FULL.
- Ordering: operands leave strictly in acceptance order.
- Stability: operand is stable while out_valid && !out_ready.

## Timing
- Latency: 1 cycle from accepting edge to out_valid/operand.
- Throughput: 1 operand/cycle while out_ready is held high.
- in_ready is registered; it has no combinational path from out_ready or in_valid.
- Reset (reset_n low, asynchronous):
  - out_valid=0, operand=0, sel_err=0, both buffer entries empty.
  - in_ready=0 while reset_n is low, and 1 on the first edge after release.
- Reset mid-operation discards both buffered operands. No partial output is produced.

## Configuration
- ALU_SRC_B_LUI_EN defined: select 6 drives imm << 16 (imm in the upper bits, zero-filled low bits, truncated to WIDTH) for load-upper-immediate.
- ALU_SRC_B_LUI_EN undefined: select 6 is illegal and behaves exactly as select 7.

## Structure
- Shared package alu_src_b_pkg holds:
  - select encodings as named constants (SRC_B_REG, SRC_B_INC, SRC_B_SEXT, SRC_B_MDR, SRC_B_SEXT_SL, SRC_B_ZEXT, SRC_B_LUI)
  - the buffer-state enum (EMPTY/ONE/FULL)
- Sub-module operand_skid_buffer (WIDTH-parametrised, two-entry valid/ready skid). The select/extend logic stays in the top.

## Test plan
- Reset: assert reset_n low mid-stream → out_valid=0, operand=0, sel_err=0 immediately; in_ready=1 one edge after release.
- Sign extension: sel=2, imm=16'h8004, out_ready=1 → operand=32'hFFFF8004 one cycle later; sel=4 same imm → 32'hFFFE0010; sel=5 → 32'h00008004.
- Backpressure: out_ready=0, issue sel=0 reg_b=0xA then sel=3 mdr=0xB → in_ready=0 after the second accept, operand stays 0xA; raise out_ready → 0xA, then 0xB on consecutive cycles, in_ready=1 again.
- Streaming: 8 back-to-back requests with sel=1 and out_ready=1 → 8 consecutive out_valid cycles, each operand=4.
- Illegal select: sel=7 → no out_valid, sel_err=1 and held; err_clr with a simultaneous sel=7 accept → sel_err stays 1; err_clr alone → 0.
- Macro: sel=6, imm=16'h1234 → operand=32'h12340000 with ALU_SRC_B_LUI_EN; without it → sel_err=1 and no output.
